tile_dump_uart_tx: RTL

- Reads the square-wave tile buffer (8 rows x 80 columns, 3-bit entries {on, pattern[1:0]}) through its spare read port and transmits it over UART as an ASCII screen dump.
- Sits beside the full-screen generator and drives the board tx pin, complementing the existing rx input.
- One dump is 8 lines, each of 80 characters followed by CR LF.

---
 rtl/tile_dump_uart_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tile_dump_uart_tx.sv
// tile_dump_uart_tx: reads the 8x80 square-wave tile buffer through its spare
// read port and sends it over UART (8N1, LSB first) as an ASCII screen dump.
// Each row is sent as one character per tile followed by CR LF.
//
// Handshake and timing notes:
//   start is level-sampled only in IDLE; busy covers the whole dump and drops
//   in the same cycle that the one-cycle done pulse is raised.
//   rd_addr is {row, col} straight from the position registers, so it changes
//   on the edge that enters FETCH. The RAM returns data two edges later, and
//   rd_data is captured on the edge that ends the first START cycle.
//   Each byte takes FETCH + WAIT + 10 bit times (10*CLKS_PER_BIT+2 cycles).
//   CLKS_PER_BIT must be at least 2.
module tile_dump_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ROWS         = 8,
    parameter int COLS         = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [9:0] rd_addr,
    input  logic [2:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    ROW_LAST  = 3'(ROWS - 1);
    localparam logic [6:0]    COL_LAST  = 7'(COLS - 1);

    // LOAD and NEXT never occupy a cycle: LOAD is merged into the first START
    // cycle and NEXT into the last STOP cycle. They are listed for reference.
    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, LOAD, START, DATA, STOP, NEXT
    } state_t;

    // Which character of the current row is being sent.
    typedef enum logic [1:0] {
        POS_TILE, POS_CR, POS_LF
    } pos_t;

    state_t         state;
    state_t         state_next;
    pos_t           pos;
    logic [2:0]     row;
    logic [6:0]     col;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [7:0]     load_byte;
    logic           baud_last;
    logic           dump_end;
    logic           done_next;

    assign rd_addr   = {row, col};
    assign busy      = (state != IDLE);
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign dump_end  = (pos == POS_LF) && (row == ROW_LAST);

    // Character for the current position: tile glyph, CR or LF.
    always_comb begin
        load_byte = 8'h2E;
        case (pos)
            POS_TILE: load_byte = rd_data[2] ? {6'b001100, rd_data[1:0]} : 8'h2E;
            POS_CR:   load_byte = 8'h0D;
            POS_LF:   load_byte = 8'h0A;
            default:  load_byte = 8'h2E;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic and the end-of-dump strobe.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: state_next = WAIT;
            WAIT:  state_next = START;
            START: if (baud_last) state_next = DATA;
            DATA:  if (baud_last && bit_idx == 3'd7) state_next = STOP;
            STOP: begin
                if (baud_last) begin
                    if (dump_end) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Serial line: high except during the start bit and data bits.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            default: tx = 1'b1;
        endcase
    end

    // Datapath: baud/bit counters, shift register, screen position, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos      <= POS_TILE;
            row      <= 3'd0;
            col      <= 7'd0;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'hFF;
            done     <= 1'b0;
        end else begin
            done <= done_next;
            if (state == START || state == DATA || state == STOP)
                baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
            else
                baud_cnt <= '0;
            case (state)
                IDLE: begin
                    bit_idx <= 3'd0;
                    if (start) begin
                        pos <= POS_TILE;
                        row <= 3'd0;
                        col <= 7'd0;
                    end
                end
                START: begin
                    if (baud_cnt == '0) shreg <= load_byte;
                end
                DATA: begin
                    if (baud_last) begin
                        shreg   <= {1'b1, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        case (pos)
                            POS_TILE: begin
                                if (col == COL_LAST) pos <= POS_CR;
                                else                 col <= col + 7'd1;
                            end
                            POS_CR: pos <= POS_LF;
                            default: begin
                                if (row != ROW_LAST) begin
                                    row <= row + 3'd1;
                                    col <= 7'd0;
                                    pos <= POS_TILE;
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
